// File: rtl/fpu_host_link_16.sv
// fpu_host_link_16: host-side end of the 10-bit chip pin protocol for the 16-bit FPU.
// Accepts {a, b, op} over valid/ready and serializes it as five framed beats on
// chip_out. It then collects the two-beat result from chip_in and presents it
// on a valid/ready response port.
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready     - request handshake; operands req_a, req_b, req_op
//   chip_out[9:0]           - {valid, first-beat marker, data byte} to chip pins
//   chip_in[9:0]            - {valid, high-byte marker, data byte} from chip pins
//   rsp_valid/rsp_ready     - response handshake; result rsp_y
//   busy                    - transaction in flight
//   timeout_err             - one-cycle pulse when a result beat never arrives
module fpu_host_link_16 #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [3:0]  req_op,
  output logic [9:0]  chip_out,
  input  logic [9:0]  chip_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_y,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);
  localparam logic [2:0] LAST_SLOT = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   a_q, a_d;
  logic [15:0]   b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic [2:0]    beat_q, beat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    y_hi_q, y_hi_d;
  logic [9:0]    chip_out_q, chip_out_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_y_q, rsp_y_d;
  logic          req_ready_q, req_ready_d;
  logic          busy_q, busy_d;
  logic          timeout_err_q, timeout_err_d;

  logic          in_hi_c;
  logic          in_lo_c;
  logic          tmo_exp_c;

  assign in_hi_c   = chip_in[9] & chip_in[8];
  assign in_lo_c   = chip_in[9] & ~chip_in[8];
  assign tmo_exp_c = (tmo_q == TMO_MAX);

  // State register and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      beat_q        <= '0;
      tmo_q         <= '0;
      y_hi_q        <= '0;
      chip_out_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_y_q       <= '0;
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      beat_q        <= beat_d;
      tmo_q         <= tmo_d;
      y_hi_q        <= y_hi_d;
      chip_out_q    <= chip_out_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_y_q       <= rsp_y_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    beat_d        = beat_q;
    tmo_d         = tmo_q;
    y_hi_d        = y_hi_q;
    chip_out_d    = 10'h000;
    rsp_y_d       = rsp_y_q;
    timeout_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          a_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
          beat_d  = 3'd0;
          state_d = ST_SEND;
        end
      end

      // Slots 0..4 emit a beat; slot 5 drives the bus idle and moves on.
      ST_SEND: begin
        unique case (beat_q)
          3'd0:    chip_out_d = {2'b11, a_q[15:8]};
          3'd1:    chip_out_d = {2'b10, a_q[7:0]};
          3'd2:    chip_out_d = {2'b10, b_q[15:8]};
          3'd3:    chip_out_d = {2'b10, b_q[7:0]};
          3'd4:    chip_out_d = {2'b10, 4'h0, op_q};
          default: chip_out_d = 10'h000;
        endcase
        if (beat_q == LAST_SLOT) begin
          tmo_d   = '0;
          state_d = ST_WAIT_HI;
        end else begin
          beat_d  = beat_q + 3'd1;
        end
      end

      // Accepted beats are checked before expiry so a late beat still wins.
      ST_WAIT_HI: begin
        if (in_hi_c) begin
          y_hi_d  = chip_in[7:0];
          tmo_d   = '0;
          state_d = ST_WAIT_LO;
        end else if (tmo_exp_c) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_WAIT_LO: begin
        if (in_lo_c) begin
          rsp_y_d = {y_hi_q, chip_in[7:0]};
          state_d = ST_RESP;
        end else if (in_hi_c) begin
          y_hi_d = chip_in[7:0];
          tmo_d  = '0;
        end else if (tmo_exp_c) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Status outputs track the state being entered so they line up with it.
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  assign req_ready   = req_ready_q;
  assign chip_out    = chip_out_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_y       = rsp_y_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fpu_host_link_16.sv
// Bench for fpu_host_link_16: directed protocol cases plus randomized transactions
// checked against a frame/response reference model.
module tb_fpu_host_link_16;

  localparam int unsigned TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_op;
  logic [9:0]  chip_out;
  logic [9:0]  chip_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_y;
  logic        busy;
  logic        timeout_err;

  int compared   = 0;
  int mismatched = 0;
  int acc_cnt    = 0;

  fpu_host_link_16 #(.TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .chip_out    (chip_out),
    .chip_in     (chip_in),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_y       (rsp_y),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!reset && req_valid && req_ready) acc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Request frame: five bytes in order, first beat marked, all valid.
  function automatic logic [9:0] exp_beat(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op, input int k);
    logic [7:0] bytes [5];
    bytes[0] = a[15:8];
    bytes[1] = a[7:0];
    bytes[2] = b[15:8];
    bytes[3] = b[7:0];
    bytes[4] = {4'h0, op};
    return {1'b1, (k == 0), bytes[k]};
  endfunction

  // Result: the latest high byte seen, completed by the first low byte after it.
  function automatic logic [15:0] resp_model(input logic [9:0] beats [$]);
    logic [7:0] hi;
    bit         have_hi;
    hi      = 8'h00;
    have_hi = 1'b0;
    foreach (beats[i]) begin
      if (beats[i][9]) begin
        if (beats[i][8]) begin
          hi      = beats[i][7:0];
          have_hi = 1'b1;
        end else if (have_hi) begin
          return {hi, beats[i][7:0]};
        end
      end
    end
    return 16'h0000;
  endfunction

  task automatic do_request(input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] op, input bit keep);
    int n;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_wait", req_ready, 1);
    tick();
    if (!keep) req_valid = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_ready_low", req_ready, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("beat%0d", k), chip_out, exp_beat(a, b, op, k));
      check("send_ready_low", req_ready, 0);
    end
    tick();
    check("send_end_idle", chip_out, 10'h000);
  endtask

  task automatic do_response(input logic [9:0] beats [$], input logic [15:0] exp_y,
                             input bit early_ready, input int hold);
    rsp_ready = early_ready;
    foreach (beats[i]) begin
      chip_in = beats[i];
      tick();
      check("wait_ready_low", req_ready, 0);
      if (i != beats.size() - 1) check("wait_no_rsp", rsp_valid, 0);
    end
    chip_in = 10'h000;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_y", rsp_y, exp_y);
    if (!early_ready) begin
      for (int h = 0; h < hold; h++) begin
        tick();
        check("rsp_hold_valid", rsp_valid, 1);
        check("rsp_hold_y", rsp_y, exp_y);
      end
      rsp_ready = 1'b1;
    end
    tick();
    rsp_ready = 1'b0;
    check("rsp_done_valid", rsp_valid, 0);
    check("rsp_done_busy", busy, 0);
    check("rsp_done_ready", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0]  q [$];
    logic [15:0] a, b, y;
    logic [3:0]  op;
    int          acc0;

    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    chip_in = '0; rsp_ready = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_chip_out", chip_out, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_y", rsp_y, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", req_ready, 1);

    // Directed: known frame, then known result with held response
    do_request(16'h3C00, 16'h4000, 4'h1, 1'b0);
    q = '{10'h342, 10'h200};
    do_response(q, 16'h4200, 1'b0, 3);

    // Low-marker beat ignored while waiting for high; high byte overwritten
    do_request(16'h1234, 16'h5678, 4'h9, 1'b0);
    q = '{10'h2AA, 10'h311, 10'h322, 10'h233};
    do_response(q, 16'h2233, 1'b0, 0);

    // Timeout waiting for the high byte
    do_request(16'hABCD, 16'hEF01, 4'h2, 1'b0);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check("tmo_hi_quiet", timeout_err, 0);
    end
    tick();
    check("tmo_hi_pulse", timeout_err, 1);
    check("tmo_hi_no_rsp", rsp_valid, 0);
    check("tmo_hi_busy", busy, 0);
    check("tmo_hi_y_kept", rsp_y, 16'h2233);
    tick();
    check("tmo_hi_pulse_end", timeout_err, 0);
    check("tmo_hi_ready", req_ready, 1);

    // Beats arriving exactly on the expiry cycle win over the timeout
    do_request(16'h0F0F, 16'hF0F0, 4'h3, 1'b0);
    repeat (TO - 1) tick();
    chip_in = 10'h355;
    tick();
    chip_in = 10'h000;
    check("expiry_hi_no_err", timeout_err, 0);
    check("expiry_hi_busy", busy, 1);
    repeat (TO - 1) tick();
    chip_in = 10'h266;
    tick();
    chip_in = 10'h000;
    check("expiry_lo_no_err", timeout_err, 0);
    check("expiry_lo_valid", rsp_valid, 1);
    check("expiry_lo_y", rsp_y, 16'h5566);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("expiry_done", rsp_valid, 0);

    // Timeout waiting for the low byte leaves rsp_y alone
    do_request(16'h1111, 16'h2222, 4'h4, 1'b0);
    chip_in = 10'h3AB;
    tick();
    chip_in = 10'h000;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check("tmo_lo_quiet", timeout_err, 0);
    end
    tick();
    check("tmo_lo_pulse", timeout_err, 1);
    check("tmo_lo_no_rsp", rsp_valid, 0);
    check("tmo_lo_y_kept", rsp_y, 16'h5566);

    // Asynchronous reset in the middle of the request frame
    tick();
    req_a = 16'hDEAD; req_b = 16'hBEEF; req_op = 4'h7; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_beat2", chip_out, exp_beat(16'hDEAD, 16'hBEEF, 4'h7, 2));
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_chip_out", chip_out, 0);
    check("async_rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    chip_in = 10'h3C1;
    tick();
    check("rel_ready", req_ready, 1);
    check("rel_busy", busy, 0);
    chip_in = 10'h2C2;
    tick();
    chip_in = 10'h000;
    check("stale_no_rsp", rsp_valid, 0);
    check("stale_chip_out", chip_out, 0);
    check("stale_busy", busy, 0);

    // req_valid held high: exactly one acceptance per transaction
    acc0 = acc_cnt;
    for (int t = 0; t < 3; t++) begin
      a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
      do_request(a, b, op, 1'b1);
      y = 16'($urandom);
      q = '{{2'b11, y[15:8]}, {2'b10, y[7:0]}};
      do_response(q, resp_model(q), 1'b0, t);
    end
    req_valid = 1'b0;
    check("accept_count", 32'(acc_cnt - acc0), 3);

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
      do_request(a, b, op, 1'b0);
      q = {};
      for (int j = 0, n = $urandom_range(0, 2); j < n; j++) begin
        if ($urandom_range(0, 1) == 1) q.push_back({2'b10, 8'($urandom)});
        else                           q.push_back({1'b0, 9'($urandom)});
      end
      for (int h = 0, nh = $urandom_range(1, 2); h < nh; h++) begin
        q.push_back({2'b11, 8'($urandom)});
        for (int j = 0, n = $urandom_range(0, 2); j < n; j++)
          q.push_back({1'b0, 9'($urandom)});
      end
      q.push_back({2'b10, 8'($urandom)});
      do_response(q, resp_model(q), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fpu_host_link_16.md
Name: fpu_host_link_16

Overview:
- Host-side end of the 10-bit chip pin protocol for the 16-bit FPU.
- Accepts an operation request (a, b, op) over a valid/ready interface.
- Serializes the request as five framed beats onto the chip's 10-bit input pins.
- Collects the two-beat 16-bit result from the chip's 10-bit output pins and presents it on a valid/ready response port. Used by the test harness / FPGA host driving the chip.

Parameters:
TIMEOUT, 64, cycles to wait for each result beat before aborting (minimum 2).

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_a  input  16  operand a
req_b  input  16  operand b
req_op  input  4  FPU operation select
chip_out  output  10  drives chip input pins; [9]=valid, [8]=first-beat marker, [7:0]=data byte
chip_in  input  10  from chip output pins; [9]=valid, [8]=high-byte marker, [7:0]=data byte
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_y  output  16  FPU result
busy  output  1  high in any state other than IDLE
timeout_err  output  1  one-cycle pulse when a result wait times out

Behaviour:
- Reset (asynchronous, active-high) forces all outputs and registers to zero immediately:
  - state=IDLE; chip_out=10'h000; rsp_valid=0; rsp_y=0; timeout_err=0; busy=0.
  - req_ready becomes 1 after reset deasserts.
- Reset mid-operation abandons the transaction; no partial beats resume.
- States: IDLE, SEND, WAIT_HI, WAIT_LO, RESP.
- IDLE:
  - req_ready=1; chip_out=10'h000.
  - On req_valid at edge T: latch a, b, op; beat counter=0; go to SEND.
- SEND: chip_out is registered, one beat per cycle on cycles T+1..T+5.
  - Beat 0: {1,1,a[15:8]}.
  - Beat 1: {1,0,a[7:0]}.
  - Beat 2: {1,0,b[15:8]}.
  - Beat 3: {1,0,b[7:0]}.
  - Beat 4: {1,0,4'h0,op}.
  - After beat 4, chip_out returns to 10'h000 on T+6. State becomes WAIT_HI and the timeout counter clears.
- WAIT_HI:
  - Waits for chip_in[9]=1 with chip_in[8]=1; latch y[15:8]; go to WAIT_LO; counter clears.
  - A valid beat with [8]=0 is ignored.
  - chip_in[9]=0 beats are always ignored.
- WAIT_LO:
  - A valid beat with [8]=0 latches y[7:0]; go to RESP.
  - A valid beat with [8]=1 overwrites y[15:8]; stay in WAIT_LO; counter clears.
- Timeout:
  - In WAIT_HI/WAIT_LO the counter increments each cycle with no accepted beat.
  - When the counter reaches TIMEOUT-1 with no beat: pulse timeout_err for one cycle, go to IDLE, rsp_y unchanged.
  - A beat arriving on the expiry cycle wins over the timeout.
- RESP:
  - rsp_valid=1; rsp_y is stable until handshake.
  - On rsp_valid && rsp_ready: rsp_valid drops next cycle; go to IDLE.
  - rsp_ready with rsp_valid low has no effect.
- Back-to-back: a new request cannot be accepted in the same cycle as the response handshake. Earliest next acceptance is the following cycle.
- Register widths: beat counter 3 bits; timeout counter sized to clog2(TIMEOUT); no arithmetic on data.

Test Plan:
1. Reset, then req a=16'h3C00, b=16'h4000, op=4'h1 accepted at T → chip_out = 10'h33C, 10'h200, 10'h240, 10'h200, 10'h201 on T+1..T+5, 10'h000 at T+6.
2. After case 1, chip_in beats 10'h342 then 10'h200 → rsp_valid=1, rsp_y=16'h4200; hold rsp_ready=0 for 3 cycles (rsp_valid stays high, rsp_y stable); rsp_ready=1 → idle, req_ready=1 next cycle.
3. In WAIT_HI drive 10'h2AA (lo marker) then 10'h311, 10'h322, 10'h233 → first beat ignored, high byte overwritten; rsp_y=16'h2233.
4. TIMEOUT=8, no chip_in beats after SEND → timeout_err pulses exactly one cycle 8 cycles after entering WAIT_HI; rsp_valid stays 0; next request accepted.
5. Assert reset during beat 2 of SEND → chip_out=10'h000 and busy=0 immediately (asynchronous), req_ready=1 after release, stale result beats ignored in IDLE.
6. Keep req_valid high continuously → exactly one acceptance per completed transaction; req_ready low throughout SEND/WAIT/RESP.
